k007232_bus_sequencer: RTL

- Host-side write sequencer for the K007232 CPU bus.
- Accepts (register address, data) commands over a valid/ready interface and buffers them in a small FIFO.
- Replays each command onto the chip's i_DACS_n / i_RD_n-write / i_AB / i_DB pins with fixed phiM-aligned strobe timing.
- Sits between the sound-CPU model (or a scripted bench) and the K007232 instance, so register programming becomes cycle-exact and repeatable.

---
 rtl/k007232_bus_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/k007232_bus_sequencer.sv
// K007232 host write sequencer: queues (addr, data) commands and replays
// them onto the chip's CPU bus with fixed phiM-aligned strobe timing.
`timescale 1ns/1ps
module k007232_bus_sequencer #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          i_EMUCLK,
  input  logic          i_RST_n,
  input  logic          i_PCEN,
  input  logic          i_NCEN,
  input  logic          i_CMD_VALID,
  output logic          o_CMD_READY,
  input  logic [3:0]    i_CMD_ADDR,
  input  logic [7:0]    i_CMD_DATA,
  input  logic          i_FLUSH,
  output logic          o_CS_n,
  output logic          o_WR_n,
  output logic [3:0]    o_AB,
  output logic [7:0]    o_DB,
  output logic          o_DB_OE,
  output logic          o_BUSY,
  output logic [LW-1:0] o_LEVEL
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CSL,
    S_DATA,
    S_WRL,
    S_HOLD,
    S_REL
  } state_t;

  state_t        r_state;
  logic [11:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [LW-1:0] r_level;
  logic [7:0]    r_dat;
  logic          r_cs_n;
  logic          r_wr_n;
  logic [3:0]    r_ab;
  logic [7:0]    r_db;
  logic          r_oe;
  logic          r_busy;

  logic          w_p;
  logic          w_n;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [11:0]   w_rd;

  // A coincident P/N pair is treated as P only.
  assign w_p     = i_PCEN;
  assign w_n     = i_NCEN & ~i_PCEN;
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = i_CMD_VALID & ~w_full & ~i_FLUSH;
  assign w_pop   = (r_state == S_IDLE) & w_p & ~w_empty;
  assign w_rd    = r_mem[r_rp];

  assign o_CMD_READY = ~w_full;
  assign o_LEVEL     = r_level;
  assign o_CS_n      = r_cs_n;
  assign o_WR_n      = r_wr_n;
  assign o_AB        = r_ab;
  assign o_DB        = r_db;
  assign o_DB_OE     = r_oe;
  assign o_BUSY      = r_busy;

  always_ff @(posedge i_EMUCLK) begin
    if (w_push)
      r_mem[r_wp] <= {i_CMD_ADDR, i_CMD_DATA};
  end

  // Flush only clears the queue; an already-popped command keeps running.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else if (i_FLUSH) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wp <= r_wp + AW'(1);
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state <= S_IDLE;
      r_dat   <= '0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_ab    <= '0;
      r_db    <= '0;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_pop) begin
          r_ab    <= w_rd[11:8];
          r_dat   <= w_rd[7:0];
          r_busy  <= 1'b1;
          r_state <= S_ADDR;
        end
        S_ADDR: if (w_n) begin
          r_cs_n  <= 1'b0;
          r_state <= S_CSL;
        end
        S_CSL: if (w_p) begin
          r_db    <= r_dat;
          r_oe    <= 1'b1;
          r_state <= S_DATA;
        end
        S_DATA: if (w_n) begin
          r_wr_n  <= 1'b0;
          r_state <= S_WRL;
        end
        // Chip samples the write while the FSM sits in WRL/HOLD.
        S_WRL: if (w_p) begin
          r_state <= S_HOLD;
        end
        S_HOLD: if (w_n) begin
          r_wr_n  <= 1'b1;
          r_cs_n  <= 1'b1;
          r_state <= S_REL;
        end
        S_REL: if (w_p) begin
          r_oe    <= 1'b0;
          r_db    <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
